// File: rtl/nano_ifetch.sv
// rtl/nano_ifetch.sv - instruction prefetch buffer between the core fetch port and program memory
// NANO_IFETCH_PREFETCH_EN enables sequential speculative streaming; undefined fetches on demand only.
module nano_ifetch #(
  parameter int WIDTHIA = 10,
  parameter int WIDTHID = 32,
  parameter int DEPTH = 4,
  parameter logic [WIDTHIA-1:0] PCRESET = 'h4
) (
  input  logic               clock,
  input  logic               sreset,
  input  logic [WIDTHIA-1:0] c_address,
  input  logic               c_read,
  output logic               c_waitrequest,
  output logic [WIDTHID-1:0] c_readdata,
  output logic               c_readdatavalid,
  output logic [WIDTHIA-1:0] m_address,
  output logic               m_read,
  input  logic               m_waitrequest,
  input  logic [WIDTHID-1:0] m_readdata,
  input  logic               m_readdatavalid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTHID-1:0] fifo_mem [DEPTH];
  logic [PW-1:0]      rd_ptr, wr_ptr;
  logic [CW-1:0]      fifo_count, outstanding, discard;
  logic [WIDTHIA-1:0] head_addr;
  logic               req_stale;

  logic               hit, empty_wait, miss, accept, push, disc_dec, load, want;
  logic [CW-1:0]      count_nxt, out_nxt, disc_nxt;
  logic [WIDTHIA-1:0] head_nxt, base_addr;

`ifdef NANO_IFETCH_PREFETCH_EN
  localparam logic [CW:0]   DEPTH_OCC = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  logic [WIDTHIA-1:0] fetch_addr;
  logic [CW:0]        occupancy;
`endif

  assign c_waitrequest = ~hit;

  always_comb begin
    hit        = c_read && (fifo_count != '0) && (c_address == head_addr);
    empty_wait = c_read && (fifo_count == '0) && (c_address == head_addr);
    miss       = c_read && !hit && !empty_wait;
    accept     = m_read && !m_waitrequest;
    disc_dec   = m_readdatavalid && (discard != '0);
    // a response landing on the flush cycle belongs to the old stream
    push       = m_readdatavalid && (discard == '0) && !miss;

    out_nxt   = outstanding + CW'(accept) - CW'(m_readdatavalid);
    count_nxt = miss ? '0 : fifo_count + CW'(push) - CW'(hit);
    // on a flush everything still in flight is stale, including this cycle's acceptance
    disc_nxt  = miss ? out_nxt : discard - CW'(disc_dec) + CW'(accept && req_stale);
    head_nxt  = miss ? c_address : (hit ? head_addr + WIDTHIA'(1) : head_addr);

    // a stalled request must stay on the bus until memory takes it
    load = !m_read || accept;
`ifdef NANO_IFETCH_PREFETCH_EN
    occupancy = {1'b0, count_nxt} + {1'b0, out_nxt} - {1'b0, disc_nxt};
    base_addr = miss ? c_address : fetch_addr;
    want      = (occupancy < DEPTH_OCC) && (out_nxt < DEPTH_CNT);
`else
    base_addr = head_nxt;
    want      = c_read && !hit && (count_nxt == '0) && (out_nxt == '0);
`endif
  end

  always_ff @(posedge clock or posedge sreset) begin
    if (sreset) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      fifo_count      <= '0;
      outstanding     <= '0;
      discard         <= '0;
      head_addr       <= PCRESET;
      req_stale       <= 1'b0;
      m_read          <= 1'b0;
      m_address       <= '0;
      c_readdata      <= '0;
      c_readdatavalid <= 1'b0;
    end else begin
      fifo_count      <= count_nxt;
      outstanding     <= out_nxt;
      discard         <= disc_nxt;
      head_addr       <= head_nxt;
      c_readdatavalid <= hit;
      if (hit) c_readdata <= fifo_mem[rd_ptr];

      if (miss) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (hit)  rd_ptr <= rd_ptr + PW'(1);
        if (push) wr_ptr <= wr_ptr + PW'(1);
      end

      if (load) begin
        m_read    <= want;
        req_stale <= 1'b0;
        if (want) m_address <= base_addr;
      end else begin
        req_stale <= req_stale || miss;
      end
    end
  end

`ifdef NANO_IFETCH_PREFETCH_EN
  always_ff @(posedge clock or posedge sreset) begin
    if (sreset) begin
      fetch_addr <= PCRESET;
    end else if (load) begin
      fetch_addr <= want ? base_addr + WIDTHIA'(1) : base_addr;
    end else if (miss) begin
      fetch_addr <= c_address;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= m_readdata;
  end

endmodule
